// File: rtl/cpu_trace_unit.sv
// cpu_trace_unit: saturating pipeline event counters with an on-demand snapshot
// record streamed over valid/ready. Optional retire counter: TRACE_RETIRE_EN.
module cpu_trace_unit (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        retire_i,
  input  logic [31:0] pc_i,
  input  logic        snap_req_i,
  input  logic        trace_ready_i,
  output logic        trace_valid_o,
  output logic [31:0] trace_data_o,
  output logic        trace_last_o,
  output logic        busy_o
);
  localparam int DATA_W = 32;
`ifdef TRACE_RETIRE_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic                capture, xfer, last_word, vld_p0;
  logic [7:0]          seq_q;
  logic                overrun_q;
  logic [DATA_W-1:0]   cycle_cnt, stall_cnt, flush_cnt;
  logic [DATA_W-1:0]   hdr_p0, cyc_p0, stl_p0, fls_p0, pc_p0;
  logic [DATA_W-1:0]   word;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v,
                                                input logic en);
    if (en && (v != {DATA_W{1'b1}})) return v + {{(DATA_W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cycle_cnt <= sat_inc(cycle_cnt, 1'b1);
      stall_cnt <= sat_inc(stall_cnt, stall_i);
      flush_cnt <= sat_inc(flush_cnt, flush_i);
    end
  end

`ifdef TRACE_RETIRE_EN
  logic [DATA_W-1:0] retire_cnt, ret_p0;

  always_ff @(posedge clk_i) begin
    if (!start_i)     retire_cnt <= '0;
    else              retire_cnt <= sat_inc(retire_cnt, retire_i);
    if (!start_i)     ret_p0 <= '0;
    else if (capture) ret_p0 <= retire_cnt;
  end
`else
  logic unused_retire;
  assign unused_retire = retire_i;
`endif

  // Stage p0: snapshot of counter values as they stood before the capture edge
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      hdr_p0 <= '0;
      cyc_p0 <= '0;
      stl_p0 <= '0;
      fls_p0 <= '0;
      pc_p0  <= '0;
    end else if (capture) begin
      hdr_p0 <= {16'hC0DE, overrun_q, 7'b0, seq_q};
      cyc_p0 <= cycle_cnt;
      stl_p0 <= stall_cnt;
      fls_p0 <= flush_cnt;
      pc_p0  <= pc_i;
    end
  end

  assign last_word = (idx_q == LAST_IDX);
  assign xfer      = (state_q == SEND) && trace_ready_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap_req_i) begin
          capture = 1'b1;
          state_d = SEND;
          idx_d   = 3'd0;
        end
      end
      SEND: begin
        if (trace_ready_i) begin
          if (last_word) begin
            state_d = IDLE;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      seq_q     <= 8'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (xfer && last_word) seq_q <= seq_q + 8'd1;
      // Requests arriving while a record is in flight are dropped but remembered
      if (capture)                              overrun_q <= 1'b0;
      else if (state_q == SEND && snap_req_i)   overrun_q <= 1'b1;
    end
  end

  always_comb begin
    word = '0;
    case (idx_q)
      3'd0: word = hdr_p0;
      3'd1: word = cyc_p0;
      3'd2: word = stl_p0;
      3'd3: word = fls_p0;
      3'd4: word = pc_p0;
`ifdef TRACE_RETIRE_EN
      3'd5: word = ret_p0;
`endif
      default: word = '0;
    endcase
  end

  // Outputs are held quiet combinationally while reset is asserted
  assign vld_p0        = start_i && (state_q == SEND);
  assign trace_valid_o = vld_p0;
  assign busy_o        = vld_p0;
  assign trace_last_o  = vld_p0 && last_word;
  assign trace_data_o  = start_i ? word : '0;

endmodule

// File: tb/tb_cpu_trace_unit.sv
// Self-checking bench for cpu_trace_unit: directed scenarios plus random traffic
// against a queue-based record model.
module tb_cpu_trace_unit;
`ifdef TRACE_RETIRE_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  logic        clk = 1'b0;
  logic        start = 1'b0, stall = 1'b0, flush = 1'b0, retire = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        snap = 1'b0, ready = 1'b1;
  logic        trace_valid_o, trace_last_o, busy_o;
  logic [31:0] trace_data_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  longint      m_cyc, m_stl, m_fls, m_ret;
  logic [7:0]  m_seq;
  logic        m_ovr;
  logic [31:0] mq[$];

  // DUT transfers observed on the output port
  logic [31:0] obs[$];
  logic        obs_last[$];

  cpu_trace_unit dut (
    .clk_i(clk), .start_i(start), .stall_i(stall), .flush_i(flush),
    .retire_i(retire), .pc_i(pc), .snap_req_i(snap), .trace_ready_i(ready),
    .trace_valid_o(trace_valid_o), .trace_data_o(trace_data_o),
    .trace_last_o(trace_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic longint sat(input longint v);
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] dummy;
    if (!start) begin
      m_cyc = 0; m_stl = 0; m_fls = 0; m_ret = 0;
      m_seq = 8'd0; m_ovr = 1'b0;
      mq.delete();
    end else begin
      if (mq.size() != 0) begin
        if (snap) m_ovr = 1'b1;
        if (ready) begin
          dummy = mq.pop_front();
          if (mq.size() == 0) m_seq = m_seq + 8'd1;
        end
      end else if (snap) begin
        mq.push_back({16'hC0DE, m_ovr, 7'b0, m_seq});
        mq.push_back(32'(m_cyc));
        mq.push_back(32'(m_stl));
        mq.push_back(32'(m_fls));
        mq.push_back(pc);
`ifdef TRACE_RETIRE_EN
        mq.push_back(32'(m_ret));
`endif
        m_ovr = 1'b0;
      end
      m_cyc = sat(m_cyc + 1);
      if (stall)  m_stl = sat(m_stl + 1);
      if (flush)  m_fls = sat(m_fls + 1);
      if (retire) m_ret = sat(m_ret + 1);
    end
  endtask

  // One clock: compare at the falling edge, then advance the model at the rising edge
  task automatic step();
    logic [2:0]  ectl;
    logic [31:0] ed;
    logic        chk_d;
    @(negedge clk);
    ectl  = 3'b000;
    ed    = 32'h0;
    chk_d = 1'b1;
    if (start && mq.size() != 0) begin
      ectl = {1'b1, (mq.size() == 1), 1'b1};
      ed   = mq[0];
    end else if (start) begin
      chk_d = 1'b0;
    end
    n_cmp++;
    if ({trace_valid_o, trace_last_o, busy_o} !== ectl) begin
      n_bad++;
      $display("FAIL ctl{valid,last,busy} @%0t: got %b expected %b", $time,
               {trace_valid_o, trace_last_o, busy_o}, ectl);
    end
    if (chk_d) chk32("data", trace_data_o, ed);
    if (trace_valid_o && ready) begin
      obs.push_back(trace_data_o);
      obs_last.push_back(trace_last_o);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic snap_pulse();
    snap = 1'b1;
    step();
    snap = 1'b0;
  endtask

  function automatic logic [31:0] obs_at(input int i);
    if (i < obs.size()) return obs[i];
    return 32'hBAAD_F00D;
  endfunction

  initial begin
    m_cyc = 0; m_stl = 0; m_fls = 0; m_ret = 0; m_seq = 8'd0; m_ovr = 1'b0;

    // Reset state and basic record
    run(3);
    start = 1'b1;
    run(10);
    pc = 32'h0000_1234;
    snap_pulse();
    pc = 32'h0;
    run(NW + 1);
    chk32("A_count", 32'(obs.size()), 32'(NW));
    chk32("A_hdr",   obs_at(0), 32'hC0DE_0000);
    chk32("A_cycle", obs_at(1), 32'd10);
    chk32("A_stall", obs_at(2), 32'd0);
    chk32("A_flush", obs_at(3), 32'd0);
    chk32("A_pc",    obs_at(4), 32'h0000_1234);
    for (int i = 0; i < NW; i++)
      chk32("A_last", 32'(i < obs_last.size() ? obs_last[i] : 1'b0), 32'(i == NW - 1));

    // Stall/flush counting, including a cycle with both
    start = 1'b0; run(1); start = 1'b1;
    obs.delete(); obs_last.delete();
    stall = 1'b1;               step();
    stall = 1'b1; flush = 1'b1; step();
    stall = 1'b1; flush = 1'b0; step();
    stall = 1'b0; flush = 1'b1; step();
    flush = 1'b0;               step();
    snap_pulse();
    run(NW + 1);
    chk32("B_hdr",   obs_at(0), 32'hC0DE_0000);
    chk32("B_cycle", obs_at(1), 32'd5);
    chk32("B_stall", obs_at(2), 32'd3);
    chk32("B_flush", obs_at(3), 32'd2);

    // Backpressure mid-record
    obs.delete(); obs_last.delete();
    snap_pulse();
    step();
    ready = 1'b0; run(4);
    ready = 1'b1; run(NW);
    chk32("C_count", 32'(obs.size()), 32'(NW));
    chk32("C_hdr",   obs_at(0), 32'hC0DE_0001);
    chk32("C_cycle", obs_at(1), 32'd12);
    chk32("C_stall", obs_at(2), 32'd3);

    // Overrun: request during SEND is dropped and flagged once
    start = 1'b0; run(1); start = 1'b1;
    obs.delete(); obs_last.delete();
    snap_pulse();
    step(); step();
    snap_pulse();
    run(NW - 3 + 1);
    snap_pulse();
    run(NW + 1);
    snap_pulse();
    run(NW + 1);
    chk32("D_count", 32'(obs.size()), 32'(3 * NW));
    chk32("D_hdr0",  obs_at(0), 32'hC0DE_0000);
    chk32("D_hdr1",  obs_at(NW), 32'hC0DE_8001);
    chk32("D_hdr2",  obs_at(2 * NW), 32'hC0DE_0002);

    // Reset mid-record aborts it and restarts seq and counters
    start = 1'b0; run(1); start = 1'b1;
    obs.delete(); obs_last.delete();
    snap_pulse();
    run(3);
    start = 1'b0; step(); start = 1'b1;
    step();
    chk32("E_aborted", 32'(obs.size()), 32'd3);
    obs.delete(); obs_last.delete();
    run(6);
    snap_pulse();
    run(NW + 1);
    chk32("E_hdr",   obs_at(0), 32'hC0DE_0000);
    chk32("E_cycle", obs_at(1), 32'd7);

    // Cycle counter saturation from a preloaded value
    start = 1'b0; run(1); start = 1'b1;
    force dut.cycle_cnt = 32'hFFFF_FFFE;
    m_cyc = 64'hFFFF_FFFE;
    step();
    release dut.cycle_cnt;
    run(4);
    obs.delete(); obs_last.delete();
    snap_pulse();
    run(NW + 1);
    chk32("F_cycle_sat", obs_at(1), 32'hFFFF_FFFF);

    // Random traffic checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 149) != 0);
      stall  = 1'($urandom_range(0, 1));
      flush  = 1'($urandom_range(0, 1));
      retire = 1'($urandom_range(0, 1));
      snap   = ($urandom_range(0, 7) == 0);
      ready  = ($urandom_range(0, 3) != 0);
      pc     = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_trace_unit.md
CPU_TRACE_UNIT -- requirements
Module: cpu_trace_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port clk_i  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 Port start_i  in  1  synchronous active-low reset; 0 = held in reset, 1 = run.
REQ-004 Port stall_i  in  1  hazard-detection stall asserted this cycle.
REQ-005 Port flush_i  in  1  IF/ID flush asserted this cycle.
REQ-006 Port retire_i  in  1  valid instruction completing write-back this cycle.
REQ-007 Port pc_i  in  32  current PC register value.
REQ-008 Port snap_req_i  in  1  request one snapshot record, sampled each cycle.
REQ-009 Port trace_ready_i  in  1  downstream sink accepts the current word.
REQ-010 Port trace_valid_o  out  1  trace_data_o holds a valid word.
REQ-011 Port trace_data_o  out  32  snapshot word.
REQ-012 Port trace_last_o  out  1  current word is the final word of the record.
REQ-013 Port busy_o  out  1  record transfer in progress.

Function
REQ-014 Counters cycle_cnt, stall_cnt, flush_cnt: 32-bit; +1 per cycle of running, stall_i=1 and flush_i=1 respectively; saturate at 0xFFFFFFFF, no wrap.
REQ-015 stall_i and flush_i both high in one cycle SHALL increment both counters.
REQ-016 Counters SHALL keep counting while a record is transferred.
REQ-017 FSM states: IDLE, SEND; reset state IDLE.
REQ-018 IDLE with snap_req_i=1: capture cycle_cnt, stall_cnt, flush_cnt and pc_i as they stand before that edge's updates; go to SEND; trace_valid_o=1 from the next cycle (1-cycle latency).
REQ-019 Record word order: header, cycle, stall, flush, pc (5 words).
REQ-020 Header = {16'hC0DE, overrun, 7'b0, seq[7:0]}; seq starts 0 and increments once per completed record, wrapping 255->0.
REQ-021 A word transfers on any edge where trace_valid_o=1 and trace_ready_i=1; trace_data_o and trace_last_o SHALL stay stable while trace_ready_i=0.
REQ-022 trace_last_o=1 only on the final word; its transfer returns the FSM to IDLE with trace_valid_o=0 the next cycle.
REQ-023 busy_o=1 in SEND.
REQ-024 snap_req_i=1 in SEND, including the last-word transfer cycle, SHALL be dropped and SHALL set a sticky overrun flag.
REQ-025 The overrun flag SHALL be reported in the next captured header and cleared at that capture.
REQ-026 Back-to-back records need at least one IDLE cycle.

Reset
REQ-027 start_i=0 at an edge SHALL clear all counters, seq, overrun and snapshot registers, and force IDLE.
REQ-028 During reset, outputs SHALL be trace_valid_o=0, trace_last_o=0, busy_o=0, trace_data_o=0.
REQ-029 Reset mid-record SHALL abort the record with no further words; seq SHALL NOT advance.

Configuration
REQ-030 Macro TRACE_RETIRE_EN defined: add a 32-bit saturating retire_cnt counting retire_i=1 cycles, append it as word 6, and move trace_last_o to word 6.
REQ-031 TRACE_RETIRE_EN undefined: retire_i is ignored, no retire_cnt exists, and the record is 5 words.

Verification
REQ-032 Release reset, hold stall_i=flush_i=0 for 10 cycles, pulse snap_req_i, ready=1 -> words 0xC0DE0000, 10, 0, 0, pc_i; last on word 5 (word 6 = retire count with TRACE_RETIRE_EN).
REQ-033 Stall 3 cycles, flush 2 cycles, with one cycle having both -> record shows stall=3, flush=2.
REQ-034 trace_ready_i=0 for 4 cycles mid-record -> valid stays 1; data and last unchanged; no word lost or duplicated.
REQ-035 snap_req_i pulsed during SEND -> ignored; next record header = 0xC0DE8001; the record after that = 0xC0DE0002.
REQ-036 Reset asserted on word 3 -> valid=0 next cycle; next record header = 0xC0DE0000, cycle count restarts from 0.
REQ-037 Preload cycle_cnt=0xFFFFFFFE, run 5 cycles -> reported cycle = 0xFFFFFFFF.
